// File: rtl/sram_axi_bridge.sv
// Two sram-like cache ports to one single-beat AXI4 master, one transaction at a time.
// Optional sticky bus_err output when BRIDGE_ERR_LATCH_EN is defined.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
`ifdef BRIDGE_ERR_LATCH_EN
    ,
    output logic        bus_err
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WRESP = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        sel_q, sel_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic        idle;
    logic        grant;
    logic        req_wr;
    logic        aw_fin;
    logic        w_fin;
    logic        rd_fire;
    logic        wr_fire;

    assign idle  = (state_q == IDLE);
    assign grant = idle && (data_req || inst_req);
    assign req_wr = data_req ? data_wr : inst_wr;

    // A channel is finished if it completed earlier or handshakes now.
    assign aw_fin = aw_done_q || awready;
    assign w_fin  = w_done_q || wready;

    assign rd_fire = (state_q == RDATA) && rvalid;
    assign wr_fire = (state_q == WRESP) && bvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = req_wr ? WADDR : RADDR;
                end
            end
            RADDR: begin
                if (arready) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (rvalid) begin
                    state_d = IDLE;
                end
            end
            WADDR: begin
                if (aw_fin && w_fin) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (bvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        case (state_q)
            IDLE: begin
                data_addr_ok = rst && data_req;
                inst_addr_ok = rst && !data_req && inst_req;
            end
            RADDR:   arvalid = 1'b1;
            RDATA:   rready  = 1'b1;
            WADDR: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
            end
            WRESP:   bready  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        inst_data_ok = (rd_fire || wr_fire) && !sel_q;
        data_data_ok = (rd_fire || wr_fire) && sel_q;
        inst_rdata   = (rd_fire && !sel_q) ? rdata : 32'd0;
        data_rdata   = (rd_fire && sel_q) ? rdata : 32'd0;
    end

    always_comb begin
        sel_d     = sel_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        if (grant) begin
            sel_d     = data_req;
            wr_d      = req_wr;
            size_d    = data_req ? data_size : inst_size;
            addr_d    = data_req ? data_addr : inst_addr;
            wdata_d   = data_req ? data_wdata : inst_wdata;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else if (state_q == WADDR) begin
            aw_done_d = aw_fin;
            w_done_d  = w_fin;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q     <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign arid    = sel_q ? DATA_ID : INST_ID;
    assign awid    = sel_q ? DATA_ID : INST_ID;
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign awsize  = {1'b0, size_q};
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign wlast   = 1'b1;
    assign wdata   = wdata_q;

    // Strobe is forced to zero unless the captured request is a store.
    always_comb begin
        wstrb = 4'b0000;
        if (wr_q) begin
            case (size_q)
                2'd0:    wstrb = 4'b0001 << addr_q[1:0];
                2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                default: wstrb = 4'b1111;
            endcase
        end
    end

`ifdef BRIDGE_ERR_LATCH_EN
    logic bus_err_q, bus_err_d;

    always_comb begin
        bus_err_d = bus_err_q;
        if ((rd_fire && rresp != 2'b00) || (wr_fire && bresp != 2'b00)) begin
            bus_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;

    logic unused_resp;
    assign unused_resp = ^{rid, bid, rlast};
`else
    logic unused_resp;
    assign unused_resp = ^{rid, bid, rlast, rresp, bresp};
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench for sram_axi_bridge: directed cache requests, reactive AXI slave,
// decoupled monitor checking AXI beats and data_ok completions.
module tb_sram_axi_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        inst_req = 0, inst_wr = 0;
    logic [1:0]  inst_size = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 0, data_wr = 0;
    logic [1:0]  data_size = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic [31:0] data_rdata;
    logic        data_addr_ok, data_data_ok;

    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
`ifdef BRIDGE_ERR_LATCH_EN
    logic        bus_err;
`endif

    sram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready)
`ifdef BRIDGE_ERR_LATCH_EN
        , .bus_err(bus_err)
`endif
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit port; bit wr; logic [31:0] rd; int lat; } ok_t;
    typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; } a_t;
    typedef struct { logic [31:0] d; logic [3:0] s; } w_t;
    ok_t okq[$];
    a_t  arq[$];
    a_t  awq[$];
    w_t  wq[$];
    logic [31:0] rdq[$];

    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0] rresp_v = 2'b00;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_tx(bit port, bit wr, logic [1:0] size,
                             logic [31:0] addr, logic [31:0] wd,
                             logic [3:0] strb, logic [31:0] rd, int lat);
        logic [3:0] id;
        id = port ? 4'd1 : 4'd0;
        if (wr) begin
            awq.push_back('{id, addr, {1'b0, size}});
            wq.push_back('{wd, strb});
            okq.push_back('{port, 1'b1, 32'd0, lat});
        end else begin
            arq.push_back('{id, addr, {1'b0, size}});
            rdq.push_back(rd);
            okq.push_back('{port, 1'b0, rd, lat});
        end
    endtask

    task automatic drive(bit port, bit wr, logic [1:0] size,
                         logic [31:0] addr, logic [31:0] wd,
                         output int gc, output int wt);
        bit ok;
        ok = 0;
        wt = 0;
        if (port) begin
            data_req = 1; data_wr = wr; data_size = size;
            data_addr = addr; data_wdata = wd;
        end else begin
            inst_req = 1; inst_wr = wr; inst_size = size;
            inst_addr = addr; inst_wdata = wd;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (port ? data_addr_ok : inst_addr_ok) begin
                ok = 1;
                wt = i;
                break;
            end
        end
        gc = cyc;
        chk(port ? "data_grant" : "inst_grant", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (port) data_req = 0;
        else inst_req = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (okq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 32'(okq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Reactive AXI slave; handshakes sampled at the edge, responses driven #1 later.
    initial begin
        bit ar_h, r_h, aw_h, w_h, b_h;
        bit rd_pend, aw_got, w_got;
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 1; rid = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        rd_pend = 0; aw_got = 0; w_got = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        forever begin
            @(posedge clk);
            ar_h = arvalid && arready;
            r_h  = rvalid && rready;
            aw_h = awvalid && awready;
            w_h  = wvalid && wready;
            b_h  = bvalid && bready;
            #1;
            if (!rst) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                rd_pend = 0; aw_got = 0; w_got = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                continue;
            end
            if (r_h) rd_pend = 0;
            if (ar_h) begin
                rd_pend = 1;
                r_cnt = 0;
                rid = arid;
                rdata = (rdq.size() > 0) ? rdq.pop_front() : 32'hDEAD_BEEF;
            end
            arready = arvalid && (ar_cnt >= ar_dly);
            ar_cnt = arvalid ? ar_cnt + 1 : 0;
            rvalid = rd_pend && (r_cnt >= r_dly);
            rresp = rvalid ? rresp_v : 2'b00;
            if (rd_pend && !rvalid) r_cnt++;
            if (aw_h) begin aw_got = 1; bid = awid; end
            if (w_h) w_got = 1;
            if (b_h) begin aw_got = 0; w_got = 0; b_cnt = 0; end
            awready = awvalid && (aw_cnt >= aw_dly);
            aw_cnt = awvalid ? aw_cnt + 1 : 0;
            wready = wvalid && (w_cnt >= w_dly);
            w_cnt = wvalid ? w_cnt + 1 : 0;
            bvalid = aw_got && w_got && (b_cnt >= b_dly);
            if (aw_got && w_got && !bvalid) b_cnt++;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat or completion.
    bit busy = 0, mon_aw = 0, mon_w = 0;
    int gcyc = 0;
    always @(negedge clk) begin
        if (!rst) begin
            busy = 0; mon_aw = 0; mon_w = 0;
        end else begin
            if (inst_addr_ok || data_addr_ok) begin
                chk("ao_idle", 32'(busy), 32'd0);
                chk("ao_excl", 32'(inst_addr_ok && (data_req || data_addr_ok)), 32'd0);
                busy = 1; gcyc = cyc; mon_aw = 0; mon_w = 0;
            end
            if (busy && (awvalid || wvalid || bready)) begin
                chk("aw_drop", 32'(awvalid && mon_aw), 32'd0);
                chk("w_drop", 32'(wvalid && mon_w), 32'd0);
                chk("b_early", 32'(bready && !(mon_aw && mon_w)), 32'd0);
            end
            if (arvalid && arready) begin
                if (arq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL ar_unexp: got addr %h expected none", araddr);
                end else begin
                    a_t e;
                    e = arq.pop_front();
                    chk("arid", 32'(arid), 32'(e.id));
                    chk("araddr", araddr, e.addr);
                    chk("arsize", 32'(arsize), 32'(e.size));
                    chk("arlen_burst", {22'd0, arlen, arburst}, 32'd1);
                end
            end
            if (awvalid && awready) begin
                mon_aw = 1;
                if (awq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL aw_unexp: got addr %h expected none", awaddr);
                end else begin
                    a_t e;
                    e = awq.pop_front();
                    chk("awid", 32'(awid), 32'(e.id));
                    chk("awaddr", awaddr, e.addr);
                    chk("awsize", 32'(awsize), 32'(e.size));
                    chk("awlen_burst", {22'd0, awlen, awburst}, 32'd1);
                end
            end
            if (wvalid && wready) begin
                mon_w = 1;
                if (wq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL w_unexp: got data %h expected none", wdata);
                end else begin
                    w_t e;
                    e = wq.pop_front();
                    chk("wdata", wdata, e.d);
                    chk("wstrb", 32'(wstrb), 32'(e.s));
                    chk("wlast", 32'(wlast), 32'd1);
                end
            end
            if (inst_data_ok || data_data_ok) begin
                chk("ok_excl", 32'(inst_data_ok && data_data_ok), 32'd0);
                if (okq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL ok_unexp: got data_ok expected none");
                end else begin
                    ok_t e;
                    e = okq.pop_front();
                    chk("ok_port", 32'(data_data_ok), 32'(e.port));
                    chk("ok_rdata", e.port ? data_rdata : inst_rdata, e.rd);
                    if (e.lat >= 0) chk("ok_lat", 32'(cyc - gcyc), 32'(e.lat));
                    chk("ok_resp_hs", e.wr ? 32'(bvalid && bready)
                                           : 32'(rvalid && rready), 32'd1);
                end
                busy = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, w0, gd, wd, gi, wi;
        #2 rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        chk("rst_oks", {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
        chk("rst_addr", araddr | awaddr | wdata, 32'd0);
        chk("rst_strb", 32'(wstrb), 32'd0);
        rst = 1;
        @(posedge clk);
        #1;

        // Inst read, zero-wait slave
        expect_tx(0, 0, 2'd2, 32'hBFC0_0000, 0, 0, 32'h3C1D_BFC0, 2);
        drive(0, 0, 2'd2, 32'hBFC0_0000, 0, g0, w0);
        chk("inst_grant_now", 32'(w0), 32'd0);
        wait_idle();

        // Simultaneous requests: data first, inst on the next IDLE
        expect_tx(1, 0, 2'd2, 32'h8000_1000, 0, 0, 32'h1122_3344, 2);
        expect_tx(0, 0, 2'd2, 32'hBFC0_0004, 0, 0, 32'h5566_7788, 2);
        fork
            drive(1, 0, 2'd2, 32'h8000_1000, 0, gd, wd);
            drive(0, 0, 2'd2, 32'hBFC0_0004, 0, gi, wi);
        join
        chk("data_grant_now", 32'(wd), 32'd0);
        chk("inst_after_data", 32'(gi - gd), 32'd3);
        wait_idle();

        // Byte store with delayed write response
        b_dly = 2;
        expect_tx(1, 1, 2'd0, 32'h8000_0003, 32'hAB00_0000, 4'b1000, 0, 4);
        drive(1, 1, 2'd0, 32'h8000_0003, 32'hAB00_0000, g0, w0);
        wait_idle();
        b_dly = 0;

        // Split AW/W: W accepted three cycles after AW
        w_dly = 3;
        expect_tx(0, 1, 2'd1, 32'h8000_0002, 32'h1234_0000, 4'b1100, 0, 5);
        drive(0, 1, 2'd1, 32'h8000_0002, 32'h1234_0000, g0, w0);
        wait_idle();
        w_dly = 0;

        // Strobe corners, zero-wait writes
        expect_tx(1, 1, 2'd2, 32'h8000_0010, 32'hCAFE_F00D, 4'b1111, 0, 2);
        drive(1, 1, 2'd2, 32'h8000_0010, 32'hCAFE_F00D, g0, w0);
        wait_idle();
        expect_tx(0, 1, 2'd0, 32'h0000_0001, 32'h0000_A500, 4'b0010, 0, 2);
        drive(0, 1, 2'd0, 32'h0000_0001, 32'h0000_A500, g0, w0);
        wait_idle();
        expect_tx(1, 1, 2'd1, 32'h8000_0020, 32'h0000_BEEF, 4'b0011, 0, 2);
        drive(1, 1, 2'd1, 32'h8000_0020, 32'h0000_BEEF, g0, w0);
        wait_idle();

        // Byte read with slow AR and R
        ar_dly = 2; r_dly = 1;
        expect_tx(1, 0, 2'd0, 32'h8000_0005, 0, 0, 32'h0000_00AA, 5);
        drive(1, 0, 2'd0, 32'h8000_0005, 0, g0, w0);
        wait_idle();
        ar_dly = 0;

        // Reset while waiting in RDATA
        r_dly = 6;
        expect_tx(0, 0, 2'd2, 32'hBFC0_0100, 0, 0, 32'h0BAD_0BAD, -1);
        drive(0, 0, 2'd2, 32'hBFC0_0100, 0, g0, w0);
        @(posedge clk);
        #3;
        rst = 0;
        #1;
        chk("mid_rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        chk("mid_rst_ok", {30'd0, inst_data_ok, inst_addr_ok}, 32'd0);
        chk("mid_rst_addr", araddr, 32'd0);
        chk("mid_rst_size_id", {25'd0, arsize, arid}, 32'd0);
        okq.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1;
        r_dly = 0;
        @(posedge clk);
        #1;
        expect_tx(0, 0, 2'd2, 32'hBFC0_0200, 0, 0, 32'h2410_0001, 2);
        drive(0, 0, 2'd2, 32'hBFC0_0200, 0, g0, w0);
        wait_idle();

`ifdef BRIDGE_ERR_LATCH_EN
        chk("bus_err_clear", 32'(bus_err), 32'd0);
        rresp_v = 2'b10;
        expect_tx(0, 0, 2'd2, 32'hBFC0_0008, 0, 0, 32'h0102_0304, 2);
        drive(0, 0, 2'd2, 32'hBFC0_0008, 0, g0, w0);
        wait_idle();
        rresp_v = 2'b00;
        chk("bus_err_set", 32'(bus_err), 32'd1);
        expect_tx(1, 0, 2'd2, 32'h8000_0040, 0, 0, 32'h0506_0708, 2);
        drive(1, 0, 2'd2, 32'h8000_0040, 0, g0, w0);
        wait_idle();
        chk("bus_err_held", 32'(bus_err), 32'd1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("arq_empty", 32'(arq.size()), 32'd0);
        chk("awq_empty", 32'(awq.size()), 32'd0);
        chk("wq_empty", 32'(wq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Downstream of the instruction cache and the data cache. Converts their two sram-like request ports (req/wr/size/addr/wdata, addr_ok/data_ok) into a single AXI4 master, 32-bit data, single-beat transfers.
- Fixed-priority arbitration, data port above instruction port.
- Exactly one transaction outstanding at a time.
- Cache write-backs (the WM path) and line refills (the RM path) both pass through this block.

Parameters:
- INST_ID, 4'd0, AXI ARID/AWID used for instruction-port transactions
- DATA_ID, 4'd1, AXI ARID/AWID used for data-port transactions

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- inst_req / inst_wr  in  1 / 1  instruction-port request, write flag
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr / inst_wdata  in  32 / 32  instruction-port address, write data
- inst_rdata  out  32  instruction-port read data
- inst_addr_ok / inst_data_ok  out  1 / 1  instruction-port accept, complete
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok  same as the inst_* set, data port
- arid  out  4
- araddr  out  32
- arsize  out  3
- arvalid  out  1
- arready  in  1
- rid  in  4
- rdata  in  32
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1
- awid  out  4
- awaddr  out  32
- awsize  out  3
- awvalid  out  1
- awready  in  1
- wdata  out  32
- wstrb  out  4
- wlast  out  1
- wvalid  out  1
- wready  in  1
- bid  in  4
- bresp  in  2
- bvalid  in  1
- bready  out  1
- Fixed AXI outputs (constants): arlen/awlen=0, burst=INCR, wlast=1.

Behaviour:
- States:
  - IDLE: no transaction outstanding
  - RADDR: arvalid=1 until arready
  - RDATA: rready=1 until rvalid
  - WADDR: awvalid and wvalid asserted; each deasserts independently on its own ready
  - WRESP: bready=1 until bvalid
- Arbitration, in IDLE only:
  - Grant data port if data_req=1, else inst port if inst_req=1.
  - The granted port sees addr_ok=1 combinationally in that same cycle.
  - The other port's addr_ok stays 0.
  - addr_ok is 0 in every non-IDLE state.
- Capture at grant: port select, wr, size, addr, wdata, all into registers.
  - Next state is RADDR if wr=0, WADDR if wr=1.
  - AXI outputs are driven only from the captured registers, never from live request inputs.
- Address and size outputs: araddr/awaddr = captured addr unchanged; arsize/awsize = {1'b0, size}.
- wstrb, from size and addr[1:0]:
  - byte: 0001/0010/0100/1000 for addr[1:0] = 0/1/2/3
  - half: 0011 for addr[1]=0, 1100 for addr[1]=1
  - word: 1111
- wdata = captured wdata, unshifted (the caches already place bytes in lane position).
- State transitions:
  - RADDR to RDATA on arvalid&arready.
  - RDATA to IDLE on rvalid&rready.
    - Granted port sees data_ok=1 for exactly that cycle.
    - Its rdata = AXI rdata in that cycle, passed through combinationally.
  - WADDR to WRESP once both AW and W handshakes have completed, in the same cycle or different cycles. Per-channel done flags are cleared on entry to WADDR.
  - WRESP to IDLE on bvalid&bready.
    - Granted port sees data_ok=1 for one cycle.
    - Its rdata = 0.
- Minimum latencies:
  - Read: grant to data_ok is 2 cycles, given zero-wait arready/rvalid.
  - Write: grant to data_ok is 2 cycles.
- A new grant is possible in the cycle after data_ok (IDLE reached). There is no back-to-back grant in the data_ok cycle itself.
- rid/bid are not checked; one outstanding transaction makes ordering trivial.
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All valid/ready outputs, addr_ok, data_ok and captured registers go to 0.
  - AXI address/data/strb outputs go to 0.
  - Reset mid-transaction abandons it with no data_ok. The interconnect is reset together with this block.
- Simultaneous inst_req and data_req in IDLE: data wins. inst_req must stay asserted; it is granted on the next IDLE.

Optional Feature:
- Macro: BRIDGE_ERR_LATCH_EN.
- With the macro defined:
  - Extra output bus_err (1 bit), reset 0.
  - bus_err is set sticky when an rvalid&rready or bvalid&bready cycle has resp != 2'b00.
  - bus_err is cleared only by reset.
  - Transaction completion is unchanged.
- Without the macro: no bus_err port, resp fields are ignored.

Test Plan:
- Inst read:
  - Stimulus: inst_req=1, wr=0, addr=0xBFC00000, size=2; arready and rvalid return 1 cycle later with rdata=0x3C1DBFC0.
  - Required: inst_addr_ok in cycle 0; araddr=0xBFC00000, arid=0, arsize=3'b010; inst_data_ok pulse with inst_rdata=0x3C1DBFC0; back to IDLE.
- Simultaneous requests:
  - Stimulus: data_req (read 0x80001000) and inst_req in the same cycle.
  - Required: data granted first (arid=1); inst_addr_ok=0 until data_data_ok completes; inst granted in the following IDLE cycle.
- Byte store:
  - Stimulus: data_wr=1, size=0, addr=0x80000003, wdata=0xAB000000.
  - Required: wstrb=4'b1000, awaddr=0x80000003, awsize=3'b000; data_data_ok only after bvalid.
- Split AW/W:
  - Stimulus: awready given 3 cycles before wready.
  - Required: awvalid drops after its handshake; wvalid holds until wready; bready only after both handshakes; exactly one data_ok.
- Reset mid-read:
  - Stimulus: rst=0 asserted while in RDATA.
  - Required: outputs 0 immediately without waiting for a clock edge; no data_ok; a fresh inst read after release completes normally.
- Error latch (BRIDGE_ERR_LATCH_EN defined):
  - Stimulus: rresp=2'b10 on a read.
  - Required: bus_err=1 from the next cycle and held; data_ok still pulses.
